// File: rtl/game_input_events.sv
// Button/timer event producer for the game FSM: debounced press strobes (M/S) and turn timeout (F).
// Optional auto-repeat of the move button is enabled by defining GAME_AUTO_REPEAT_EN.
module game_input_events #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned TURN_SECONDS    = 15,
  parameter int unsigned REPEAT_CYCLES   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_move,
  input  logic       btn_select,
  input  logic       timer_run,
  input  logic       timer_clr,
  output logic       enable,
  output logic       M,
  output logic       S,
  output logic       F,
  output logic [4:0] turn_sec
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PsW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PsW-1:0] PsLast   = PsW'(CLK_HZ - 1);
  localparam logic [4:0]     TurnInit = 5'(TURN_SECONDS);

  if (CLK_HZ < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      TURN_SECONDS < 1 || TURN_SECONDS > 31) begin : g_bad_cfg
    $error("game_input_events: illegal parameter value");
  end

  // Bit 0 is the move button, bit 1 the select button.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     acc_q, acc_d;
  logic [1:0]     acc_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  logic [1:0]     press;
  logic           move_press, sel_press;

  logic [PsW-1:0] presc_q, presc_d;
  logic [4:0]     turn_q, turn_d;
  logic           tick, timeout;

  logic           rpt_fire;
  logic           enable_q, m_q, s_q, f_q;
  logic           m_d, s_d, f_d;

  assign btn_raw = {btn_select, btn_move};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      acc_d[b]    = acc_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != acc_q[b]) begin
        if (db_cnt_q[b] == DbLast) begin
          acc_d[b] = ~acc_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
        end
      end
    end
  end

  // Releases are deliberately ignored: only a rising accepted state is an event.
  assign press      = acc_q & ~acc_prev_q;
  assign move_press = press[0];
  assign sel_press  = press[1];

  assign tick = timer_run && (presc_q == PsLast);

  always_comb begin
    presc_d = presc_q;
    if (timer_clr) begin
      presc_d = '0;
    end else if (timer_run) begin
      presc_d = tick ? '0 : presc_q + PsW'(1);
    end
  end

  // A select press starts a new turn but a coincident timeout is still reported.
  always_comb begin
    turn_d  = turn_q;
    timeout = 1'b0;
    if (timer_clr) begin
      turn_d = TurnInit;
    end else begin
      timeout = tick && (turn_q <= 5'd1);
      if (sel_press || timeout) begin
        turn_d = TurnInit;
      end else if (tick) begin
        turn_d = turn_q - 5'd1;
      end
    end
  end

`ifdef GAME_AUTO_REPEAT_EN
  localparam int unsigned RpW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_CYCLES - 1);

  logic [RpW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic           move_held;

  // Held means accepted high on this and the previous cycle, so the press cycle itself is skipped.
  assign move_held = acc_q[0] & acc_prev_q[0];

  always_comb begin
    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if (move_held) begin
      if (rpt_cnt_q == RpLast) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RpW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    m_d = move_press | rpt_fire;
    s_d = sel_press;
    f_d = timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      acc_q       <= '0;
      acc_prev_q  <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      presc_q     <= '0;
      turn_q      <= TurnInit;
      enable_q    <= 1'b0;
      m_q         <= 1'b0;
      s_q         <= 1'b0;
      f_q         <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      acc_q       <= acc_d;
      acc_prev_q  <= acc_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      presc_q     <= presc_d;
      turn_q      <= turn_d;
      enable_q    <= m_d | s_d | f_d;
      m_q         <= m_d;
      s_q         <= s_d;
      f_q         <= f_d;
    end
  end

  assign enable   = enable_q;
  assign M        = m_q;
  assign S        = s_q;
  assign F        = f_q;
  assign turn_sec = turn_q;

endmodule
